// File: rtl/kmac_pkg.sv
// Shared types and helpers for the KMAC prefix sequencer.
package kmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_NLEN,
    ST_NDAT,
    ST_SLEN,
    ST_SDAT,
    ST_PAD,
    ST_DONE
  } kmac_prefix_state_t;

  localparam int KMAC128_RATE_BYTES = 168;
  localparam int KMAC256_RATE_BYTES = 136;

  // Number of value bytes left_encode(v) produces for a 16-bit v.
  function automatic logic [1:0] left_enc_len(input logic [15:0] v);
    return (v < 16'd256) ? 2'd1 : 2'd2;
  endfunction

  // Byte idx of left_encode(v): length byte first, then value MSB first.
  function automatic logic [7:0] left_enc_byte(input logic [15:0] v, input logic [1:0] idx);
    if (left_enc_len(v) == 2'd1)
      return (idx == 2'd0) ? 8'h01 : v[7:0];
    case (idx)
      2'd0:    return 8'h02;
      2'd1:    return v[15:8];
      default: return v[7:0];
    endcase
  endfunction

endpackage

// File: rtl/kmac_prefix_ctrl_if.sv
// Byte-stream handshake between the prefix sequencer and the absorb packer.
interface kmac_prefix_ctrl_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_byte, output out_valid, output out_last, input out_ready);
  modport slave  (input out_byte, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/kmac_prefix_ctrl_enc8.sv
// Bit-order conversion of one stream byte (MSB<->LSB swap).
// Only built when KMAC_PREFIX_ENC8_EN is defined.
`ifdef KMAC_PREFIX_ENC8_EN
module enc8_kmac (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = {din[0], din[1], din[2], din[3], din[4], din[5], din[6], din[7]};
endmodule
`endif

// File: rtl/kmac_prefix_ctrl.sv
// KMAC prefix sequencer: streams bytepad(encode_string(N) || encode_string(S), w)
// one byte per handshake. Optional bit-order conversion under KMAC_PREFIX_ENC8_EN.
module kmac_prefix_ctrl
  import kmac_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int RATE_BYTES = KMAC128_RATE_BYTES,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [MAX_LEN-1:0][7:0] n_bytes,
  input  logic [LW-1:0]           n_len,
  input  logic [MAX_LEN-1:0][7:0] s_bytes,
  input  logic [LW-1:0]           s_len,
  output logic                    busy,
  output logic                    done,
  kmac_prefix_ctrl_if.master      ob
);

  localparam int SW = LW + 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] RATE_V   = 16'(RATE_BYTES);
  localparam logic [7:0]  LAST_CNT = 8'(RATE_BYTES - 2);

  kmac_prefix_state_t     state, nstate_c, ld_state;
  logic [SW-1:0]          sub, nsub_c, ld_sub;
  logic [7:0]             cnt;
  logic [MAX_LEN-1:0][7:0] n_r, s_r;
  logic [LW-1:0]          n_len_r, s_len_r;
  logic [15:0]            n_bits, s_bits;
  logic [SW-1:0]          hdr_last, nlen_last, slen_last, n_last, s_last;
  logic [7:0]             byte_c, enc_c;
  logic                   hs;

  assign hs        = ob.out_valid & ob.out_ready;
  assign n_bits    = 16'({n_len_r, 3'b000});
  assign s_bits    = 16'({s_len_r, 3'b000});
  assign hdr_last  = SW'(left_enc_len(RATE_V));
  assign nlen_last = SW'(left_enc_len(n_bits));
  assign slen_last = SW'(left_enc_len(s_bits));
  assign n_last    = SW'(n_len_r) - SW'(1);
  assign s_last    = SW'(s_len_r) - SW'(1);

  // Position of the byte following the one on the bus. The final byte of the
  // block is flagged by cnt, so every section end may fall through to PAD.
  always_comb begin
    nstate_c = state;
    nsub_c   = sub + SW'(1);
    case (state)
      ST_HDR:  if (sub == hdr_last) begin nstate_c = ST_NLEN; nsub_c = '0; end
      ST_NLEN: if (sub == nlen_last) begin
                 nstate_c = (n_len_r != '0) ? ST_NDAT : ST_SLEN;
                 nsub_c   = '0;
               end
      ST_NDAT: if (sub == n_last) begin nstate_c = ST_SLEN; nsub_c = '0; end
      ST_SLEN: if (sub == slen_last) begin
                 nstate_c = (s_len_r != '0) ? ST_SDAT : ST_PAD;
                 nsub_c   = '0;
               end
      ST_SDAT: if (sub == s_last) begin nstate_c = ST_PAD; nsub_c = '0; end
      ST_PAD:  nsub_c = '0;
      default: nsub_c = '0;
    endcase
    if (state == ST_IDLE) begin
      ld_state = ST_HDR;
      ld_sub   = '0;
    end else begin
      ld_state = nstate_c;
      ld_sub   = nsub_c;
    end
  end

  // Byte value at the position about to be loaded into the output register.
  always_comb begin
    byte_c = 8'h00;
    case (ld_state)
      ST_HDR:  byte_c = left_enc_byte(RATE_V, ld_sub[1:0]);
      ST_NLEN: byte_c = left_enc_byte(n_bits, ld_sub[1:0]);
      ST_NDAT: byte_c = n_r[ld_sub[IW-1:0]];
      ST_SLEN: byte_c = left_enc_byte(s_bits, ld_sub[1:0]);
      ST_SDAT: byte_c = s_r[ld_sub[IW-1:0]];
      default: byte_c = 8'h00;
    endcase
  end

`ifdef KMAC_PREFIX_ENC8_EN
  enc8_kmac u_enc8 (.din(byte_c), .dout(enc_c));
`else
  assign enc_c = byte_c;
`endif

  // Sequencer FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sub          <= '0;
      cnt          <= '0;
      n_r          <= '0;
      s_r          <= '0;
      n_len_r      <= '0;
      s_len_r      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ob.out_byte  <= 8'h00;
      ob.out_valid <= 1'b0;
      ob.out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          n_r          <= n_bytes;
          s_r          <= s_bytes;
          n_len_r      <= (n_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : n_len;
          s_len_r      <= (s_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : s_len;
          cnt          <= '0;
          state        <= ld_state;
          sub          <= ld_sub;
          busy         <= 1'b1;
          ob.out_byte  <= enc_c;
          ob.out_valid <= 1'b1;
          ob.out_last  <= 1'b0;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: if (hs) begin
          if (ob.out_last) begin
            state        <= ST_DONE;
            sub          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
            ob.out_byte  <= 8'h00;
            ob.out_valid <= 1'b0;
            ob.out_last  <= 1'b0;
          end else begin
            state       <= ld_state;
            sub         <= ld_sub;
            cnt         <= cnt + 8'd1;
            ob.out_byte <= enc_c;
            ob.out_last <= (cnt == LAST_CNT);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmac_prefix_ctrl.sv
// Self-checking bench for kmac_prefix_ctrl: vector table, hand-written
// stall/start/reset sequences and randomized blocks against a queue model.
module tb_kmac_prefix_ctrl;
  localparam int MAX_LEN = 32;
  localparam int RATE    = 168;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [MAX_LEN-1:0][7:0] n_bytes = '0;
  logic [MAX_LEN-1:0][7:0] s_bytes = '0;
  logic [LW-1:0] n_len = '0;
  logic [LW-1:0] s_len = '0;
  logic busy, done;

  kmac_prefix_ctrl_if ob();

  kmac_prefix_ctrl #(.MAX_LEN(MAX_LEN), .RATE_BYTES(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .n_bytes(n_bytes), .n_len(n_len), .s_bytes(s_bytes), .s_len(s_len),
    .busy(busy), .done(done), .ob(ob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef KMAC_PREFIX_ENC8_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
`else
    return b;
`endif
  endfunction

  task automatic push_le(input int v);
    if (v < 256) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'(v));
    end else begin
      exp_q.push_back(8'h02);
      exp_q.push_back(8'(v >> 8));
      exp_q.push_back(8'(v));
    end
  endtask

  // Reference: the whole padded prefix block as a byte list.
  task automatic build_model();
    int nl, sl;
    nl = (int'(n_len) > MAX_LEN) ? MAX_LEN : int'(n_len);
    sl = (int'(s_len) > MAX_LEN) ? MAX_LEN : int'(s_len);
    exp_q.delete();
    push_le(RATE);
    push_le(nl * 8);
    for (int i = 0; i < nl; i++) exp_q.push_back(n_bytes[i]);
    push_le(sl * 8);
    for (int i = 0; i < sl; i++) exp_q.push_back(s_bytes[i]);
    while (exp_q.size() < RATE) exp_q.push_back(8'h00);
    foreach (exp_q[i]) exp_q[i] = conv(exp_q[i]);
  endtask

  // mode 0: ready high; 1: 3-cycle stall at byte 5; 2: random ready;
  // 3: ready high, start pulsed during PAD and during the DONE cycle.
  task automatic run_blk(input string tag, input int mode);
    int idx = 0, cyc = 0, stall = 0;
    bit got = 0, hold = 0, all_rdy = 1, pulsed = 0;
    logic [7:0] hb = 0;
    logic hl = 0, r;
    build_model();
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    ob.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    chk({tag, ".first_valid"}, 32'(ob.out_valid), 32'd1);
    while (!got && cyc < 4000) begin
      cyc++;
      start = 1'b0;
      if (hold) begin
        chk({tag, ".hold_valid"}, 32'(ob.out_valid), 32'd1);
        chk({tag, ".hold_byte"}, 32'(ob.out_byte), 32'(hb));
        chk({tag, ".hold_last"}, 32'(ob.out_last), 32'(hl));
      end
      case (mode)
        1: begin r = 1'b1; if (idx == 5 && stall < 3) begin r = 1'b0; stall++; end end
        2: r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      if (!r) all_rdy = 0;
      ob.out_ready = r;
      if (done) begin
        got = 1;
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
        chk({tag, ".done_count"}, 32'(idx), 32'(RATE));
        if (all_rdy) chk({tag, ".done_cycle"}, 32'(cyc), 32'(RATE + 1));
        if (mode == 3) start = 1'b1;
      end else if (ob.out_valid && r) begin
        if (idx < RATE) begin
          chk({tag, ".byte"}, 32'(ob.out_byte), 32'(exp_q[idx]));
          chk({tag, ".last"}, 32'(ob.out_last), 32'(idx == RATE - 1));
        end else chk({tag, ".overrun"}, 32'(idx), 32'(RATE - 1));
        got_q.push_back(ob.out_byte);
        idx++;
        hold = 0;
      end else if (ob.out_valid) begin
        hold = 1; hb = ob.out_byte; hl = ob.out_last;
      end else hold = 0;
      if (mode == 3 && idx == 60 && !pulsed) begin
        pulsed = 1;
        start = 1'b1;
        n_len = LW'(7);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) chk({tag, ".done_timeout"}, 32'd0, 32'd1);
    chk({tag, ".after_done"}, 32'(done), 32'd0);
    chk({tag, ".after_busy"}, 32'(busy), 32'd0);
    chk({tag, ".after_valid"}, 32'(ob.out_valid), 32'd0);
  endtask

  task automatic fill(input int nl, input int sl, input logic [31:0] npre);
    n_len = LW'(nl);
    s_len = LW'(sl);
    for (int i = 0; i < MAX_LEN; i++) begin
      n_bytes[i] = (i < 4) ? npre[31 - 8*i -: 8] : 8'(8'hA0 + i);
      s_bytes[i] = 8'(i + 1);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".valid"}, 32'(ob.out_valid), 32'd0);
    chk({tag, ".last"}, 32'(ob.out_last), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".byte"}, 32'(ob.out_byte), 32'd0);
  endtask

  typedef struct {
    int          nl;
    int          sl;
    logic [31:0] npre;
    logic [79:0] head;
  } vec_t;

  vec_t tv[5];

  initial begin
    int ndone;
    logic [79:0] h;
    tv[0] = '{0,  0,  32'h0,        80'h01A8_0100_0100_0000_0000};
    tv[1] = '{4,  0,  32'h4B4D4143, 80'h01A8_0120_4B4D_4143_0100};
    tv[2] = '{0,  32, 32'h0,        80'h01A8_0100_0201_0001_0203};
    tv[3] = '{40, 0,  32'h4B4D4143, 80'h01A8_0201_004B_4D41_43A4};
    tv[4] = '{3,  5,  32'h4B4D4143, 80'h01A8_0118_4B4D_4101_2801};
    ob.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      fill(tv[t].nl, tv[t].sl, tv[t].npre);
      run_blk($sformatf("vec%0d", t), 0);
      chk($sformatf("vec%0d.len", t), 32'(got_q.size()), 32'(RATE));
      h = tv[t].head;
      for (int i = 0; i < 10 && i < got_q.size(); i++)
        chk($sformatf("vec%0d.head%0d", t, i), 32'(got_q[i]), 32'(conv(h[79 - 8*i -: 8])));
    end

    fill(4, 0, 32'h4B4D4143);
    run_blk("stall", 1);
    chk("stall.len", 32'(got_q.size()), 32'(RATE));

    fill(4, 4, 32'h4B4D4143);
    run_blk("start_pad", 3);

    // Reset for one cycle while S bytes are streaming.
    fill(4, 8, 32'h4B4D4143);
    ob.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk_idle("midrst");
    ndone = 0;
    repeat (200) begin @(negedge clk); if (done || busy) ndone++; end
    chk("midrst.no_done", 32'(ndone), 32'd0);
    run_blk("post_rst", 0);

    for (int k = 0; k < 12; k++) begin
      n_len = LW'($urandom_range(0, MAX_LEN + 4));
      s_len = LW'($urandom_range(0, MAX_LEN + 4));
      for (int i = 0; i < MAX_LEN; i++) begin
        n_bytes[i] = 8'($urandom);
        s_bytes[i] = 8'($urandom);
      end
      run_blk($sformatf("rnd%0d", k), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmac_prefix_ctrl.md
# kmac_prefix_ctrl

Sequencer that produces the KMAC prefix block bytepad(encode_string(N) || encode_string(S), w) as a byte stream. N is the function-name string and S is the customization string. It captures both strings on `start` and emits left_encode headers, string bytes and zero padding with a valid/ready handshake, one byte per cycle. It sits between the KMAC configuration registers and the absorb-side byte packer of the Keccak core.

## Interface
- `MAX_LEN`, default 32: maximum byte length of N and of S.
- `RATE_BYTES`, default 168: bytepad width w (168 for KMAC128, 136 for KMAC256). Legal range is 2*MAX_LEN+8 to 255.
- `LW` (localparam) = `$clog2(MAX_LEN+1)`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request one prefix generation. Ignored while `busy`.
- `n_bytes` in 8 x MAX_LEN: N, byte 0 first.
- `n_len` in LW: N length in bytes.
- `s_bytes` in 8 x MAX_LEN: S, byte 0 first.
- `s_len` in LW: S length in bytes.
- `busy` out 1: generation in progress.
- `out_byte` out 8: stream data.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_last` out 1: marks the final byte of the block.
- `done` out 1: one-cycle completion pulse.

## Operation
- Clock and reset are fixed: one clock `clk`; reset `rst_n` is synchronous and active-low. All state changes on the rising edge of `clk`.
- On `start` in IDLE, the block registers `n_bytes`, `s_bytes`, `n_len` and `s_len`. Lengths above MAX_LEN are clamped to MAX_LEN. It also clears the emitted-byte counter `cnt`, which runs modulo RATE_BYTES.
- left_encode(v), where v is a 16-bit value:
  - v < 256: emits 0x01, v.
  - otherwise: emits 0x02, v[15:8], v[7:0].
  - v = 0 emits 0x01 0x00.
- String bit length is len*8, computed in 16 bits with no overflow.
- Emission order:
  1. HDR: left_encode(RATE_BYTES).
  2. NLEN: left_encode(n_len*8).
  3. NDAT: n_len bytes of N.
  4. SLEN: left_encode(s_len*8).
  5. SDAT: s_len bytes of S.
  6. PAD: 0x00 bytes until `cnt` wraps to 0.
- States: IDLE -> HDR -> NLEN -> NDAT -> SLEN -> SDAT -> PAD -> DONE -> IDLE.
  - A zero-length string skips its DAT state.
  - If `cnt` is 0 on leaving SDAT, PAD is skipped and `out_last` goes on the final S-side byte instead.
- A sub-index counter selects the byte within a header or string. It advances only on a handshake (`out_valid && out_ready`).
- `out_last` is high together with `out_valid` on the final byte, and only then.
- DONE lasts one cycle: `done`=1, `busy`=0, then IDLE.
- `start` while busy has no effect. `start` in the DONE cycle is also ignored.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_last`=0, `done`=0, `out_byte`=0x00. State is IDLE and counters are 0.
- Outputs are registered. The first byte is valid the cycle after `start` is sampled. `busy` rises in that same cycle.
- Throughput is one byte per cycle while `out_ready`=1. With `out_ready` held high, `done` pulses exactly RATE_BYTES+1 cycles after `start`.
- While `out_valid && !out_ready`: `out_byte`, `out_last` and `out_valid` hold stable. `out_valid` never drops without a handshake.
- `done` pulses in the cycle after the last handshake.
- Reset mid-operation: on the next edge with `rst_n`=0, all outputs and state return to reset values. The partial block is discarded and there is no `done`.

## Configuration
- Macro `KMAC_PREFIX_ENC8_EN`.
  - Defined: every emitted byte passes through an `enc8_kmac` instance (bit-order conversion) before the `out_byte` register. Latency is unchanged.
  - Undefined: bytes are emitted as-is and no `enc8_kmac` is instantiated.

## Structure
- Package `kmac_pkg` holds:
  - the state enum type `kmac_prefix_state_t`;
  - constants `KMAC128_RATE_BYTES`=168 and `KMAC256_RATE_BYTES`=136;
  - a function `left_enc_len(v)` returning the byte count (1 or 2) of v.
- Sub-module: `enc8_kmac`, instantiated only under `KMAC_PREFIX_ENC8_EN`. There are no other sub-modules.

## Test plan
- N empty, S empty, `out_ready`=1, RATE=168, macro off -> bytes 01 A8 01 00 01 00 followed by 162 x 00 (168 bytes total). `out_last` on byte 168; `done` the next cycle.
- N="KMAC" (4B 4D 41 43), S empty -> 01 A8 01 20 4B 4D 41 43 01 00 followed by 158 x 00.
- S = 32 bytes, N empty -> the S header is 02 01 00. Total is still 168 bytes, with 129 padding bytes.
- `out_ready` toggled low for 3 cycles mid-NDAT -> the held byte is stable, no byte is lost or duplicated, and the stream matches the reference sequence.
- `start` pulsed during PAD, and `rst_n` low for 1 cycle during SDAT -> the `start` is ignored; after reset all outputs are 0, there is no `done`, and a new `start` produces a correct full block.
- Macro on, N="KMAC", RATE=136 -> every byte is the bit-converted version of 01 88 01 20 4B 4D 41 43 01 00 followed by 126 x 00 (136 bytes total).
